// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared states, GMII framing constants and keep decoding for the TX serializer
package eth_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_ABORT,
    ST_DRAIN,
    ST_IFG
  } tx_state_e;
  localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] ETH_SFD_BYTE = 8'hD5;
  localparam int ETH_PREAMBLE_LEN = 7;
  localparam int BYTE_W = 8;
  // Highest set keep bit + 1; an all-zero keep means the whole word is valid.
  function automatic int keep_to_nbytes(input logic [63:0] keep, input int bytes);
    int n;
    n = bytes;
    if (keep != '0)
      for (int i = 0; i < 64; i++)
        if (keep[i]) n = i + 1;
    return n;
  endfunction
endpackage

// File: rtl/gmii_tx_serializer.sv
// gmii_tx_serializer: stream words in, GMII bytes out with preamble/SFD, underflow abort and IFG
module gmii_tx_serializer
  import eth_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit PREAMBLE_EN = 1'b1,
  parameter int IFG_BYTES = 12,
  localparam int BYTES = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [BYTES-1:0]  s_keep_i,
  input  logic              s_last_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [7:0]        gmii_txd_o,
  output logic              gmii_tx_en_o,
  output logic              gmii_tx_er_o,
  output logic              busy_o,
  output logic              underflow_o
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  // The accept cycle in IDLE is part of the gap, so IFG itself lasts one cycle less.
  localparam tx_state_e GAP_ST = (IFG_BYTES > 1) ? ST_IFG : ST_IDLE;
  tx_state_e         state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, lidx_q, lidx_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              last_q, last_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ready_q, ready_d, en_q, en_d, er_q, er_d;
  logic [7:0]        txd_q, txd_d;
  logic              load;
  // Next state, holding word and counters; outputs are derived from the next values so they register in step
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lidx_d  = lidx_q;
    hold_d  = hold_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: if (s_valid_i) begin
        load    = 1'b1;
        state_d = PREAMBLE_EN ? ST_PREAMBLE : ST_DATA;
      end
      ST_PREAMBLE: begin
        state_d = (cnt_q == 16'(ETH_PREAMBLE_LEN)) ? ST_DATA : ST_PREAMBLE;
        cnt_d   = cnt_q + 16'd1;
      end
      ST_DATA: if (idx_q != lidx_q) idx_d = idx_q + IW'(1);
      else if (last_q) begin
        state_d = GAP_ST;
        cnt_d   = '0;
      end else if (s_valid_i) load = 1'b1;
      else state_d = ST_ABORT;
      ST_ABORT: state_d = ST_DRAIN;
      ST_DRAIN: if (s_valid_i && s_last_i) begin
        state_d = GAP_ST;
        cnt_d   = '0;
      end
      ST_IFG: begin
        state_d = (cnt_q == 16'(IFG_BYTES - 2)) ? ST_IDLE : ST_IFG;
        cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      hold_d = s_data_i;
      last_d = s_last_i;
      lidx_d = s_last_i ? IW'(keep_to_nbytes(64'(s_keep_i), BYTES) - 1) : IW'(BYTES - 1);
      idx_d  = '0;
      cnt_d  = '0;
    end
    ready_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN) ||
              (state_d == ST_DATA && !last_d && idx_d == IW'(BYTES - 1));
    en_d    = (state_d == ST_PREAMBLE) || (state_d == ST_DATA) || (state_d == ST_ABORT);
    er_d    = (state_d == ST_ABORT);
    txd_d   = (state_d == ST_PREAMBLE) ? ((cnt_d == 16'(ETH_PREAMBLE_LEN)) ? ETH_SFD_BYTE : ETH_PREAMBLE_BYTE) :
              (state_d == ST_DATA) ? hold_d[{idx_d, 3'b000} +: 8] : 8'h00;
  end
  // State, datapath and registered interface outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lidx_q  <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lidx_q  <= lidx_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      er_q    <= er_d;
      txd_q   <= txd_d;
    end
  end
  assign s_ready_o    = ready_q;
  assign gmii_txd_o   = txd_q;
  assign gmii_tx_en_o = en_q;
  assign gmii_tx_er_o = er_q;
  assign underflow_o  = er_q;
  assign busy_o       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_gmii_tx_serializer.sv
// tb_gmii_tx_serializer: randomized frames against a byte-stream scoreboard, plus directed corner cases
module tb_gmii_tx_serializer;
  localparam int IFG = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last, s_valid, s_ready, tx_en, tx_er, busy, uflow;
  logic [7:0]  txd;
  logic [7:0]  s2_data;
  logic        s2_keep, s2_last, s2_valid, s2_ready, tx2_en, tx2_er, busy2, uflow2;
  logic [7:0]  txd2;
  gmii_tx_serializer #(.DATA_W(32), .PREAMBLE_EN(1'b1), .IFG_BYTES(IFG)) dut (
    .clk(clk), .rst(rst), .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .gmii_txd_o(txd), .gmii_tx_en_o(tx_en),
    .gmii_tx_er_o(tx_er), .busy_o(busy), .underflow_o(uflow));
  gmii_tx_serializer #(.DATA_W(8), .PREAMBLE_EN(1'b0), .IFG_BYTES(IFG)) dut2 (
    .clk(clk), .rst(rst), .s_data_i(s2_data), .s_keep_i(s2_keep), .s_last_i(s2_last),
    .s_valid_i(s2_valid), .s_ready_o(s2_ready), .gmii_txd_o(txd2), .gmii_tx_en_o(tx2_en),
    .gmii_tx_er_o(tx2_er), .busy_o(busy2), .underflow_o(uflow2));

  typedef struct {logic [7:0] d; logic er; logic first; logic exact;} exp_t;
  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  bit          have_prev = 1'b0;
  bit          last_er = 1'b0;
  int          idle = 0;
  logic [31:0] wbuf[4];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int keep_n(input logic [3:0] k);
    int n;
    n = 4;
    if (k != 4'h0) begin
      n = 1;
      if (k[1]) n = 2;
      if (k[2]) n = 3;
      if (k[3]) n = 4;
    end
    return n;
  endfunction

  // Monitor: every enabled byte is popped and compared; idle cycles check gap length and quiet outputs
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (tx_en) begin
        if (q.size() == 0) chk("extra_byte", {24'h0, txd}, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("txd", {24'h0, txd}, {24'h0, e.d});
          chk("tx_er", {31'h0, tx_er}, {31'h0, e.er});
          chk("underflow", {31'h0, uflow}, {31'h0, e.er});
          if (e.first && have_prev) begin
            if (e.exact) chk("gap_exact", idle, IFG);
            else chk("gap_min", {31'h0, idle >= IFG}, 32'd1);
          end
          have_prev = 1'b1;
          last_er = e.er;
          idle = 0;
        end
      end else begin
        idle++;
        chk("idle_outputs", {23'h0, txd, tx_er, uflow}, 32'h0);
        if (have_prev && !last_er && idle <= IFG - 1) chk("ready_in_ifg", {31'h0, s_ready}, 32'h0);
      end
    end
  end

  // Drive one word from a negedge, hold it until accepted, return at the negedge after the accepting edge
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    s_data = d;
    s_keep = k;
    s_last = l;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic frame(input int nw, input logic [3:0] k, input bit ex, input bit uf, input bit lat);
    for (int i = 0; i < 8; i++)
      q.push_back('{d: (i == 7) ? 8'hD5 : 8'h55, er: 1'b0, first: (i == 0), exact: ex});
    if (uf) begin
      for (int b = 0; b < 4; b++) q.push_back('{d: wbuf[0][8*b +: 8], er: 1'b0, first: 1'b0, exact: 1'b0});
      q.push_back('{d: 8'h00, er: 1'b1, first: 1'b0, exact: 1'b0});
      send(wbuf[0], 4'($urandom), 1'b0);
      repeat (20) @(negedge clk);
      for (int j = 0; j < 3; j++) send($urandom, 4'($urandom), 1'b0);
      send($urandom, 4'($urandom), 1'b1);
    end else begin
      for (int i = 0; i < nw; i++)
        for (int b = 0; b < ((i == nw - 1) ? keep_n(k) : 4); b++)
          q.push_back('{d: wbuf[i][8*b +: 8], er: 1'b0, first: 1'b0, exact: 1'b0});
      for (int i = 0; i < nw; i++) begin
        send(wbuf[i], (i == nw - 1) ? k : 4'($urandom), i == nw - 1);
        if (lat && i == 0) chk("latency_first_preamble", {23'h0, tx_en, txd}, {23'h0, 1'b1, 8'h55});
      end
    end
  endtask

  task automatic wait_quiet(input string n);
    int c;
    c = 0;
    while ((q.size() != 0 || busy) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk(n, q.size(), 0);
  endtask

  initial begin
    bit prev_uf, ins, uf;
    int nw;
    s_data = '0; s_keep = '0; s_last = 1'b0; s_valid = 1'b0;
    s2_data = '0; s2_keep = 1'b0; s2_last = 1'b0; s2_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {20'h0, s_ready, tx_en, tx_er, uflow, busy, txd}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {30'h0, s_ready, busy}, 32'h2);
    mon_en = 1'b1;
    wbuf[0] = 32'h4433_2211; wbuf[1] = 32'h8877_6655;
    frame(2, 4'hF, 1'b0, 1'b0, 1'b1);
    wbuf[0] = 32'hDDCC_BBAA;
    frame(1, 4'b0011, 1'b1, 1'b0, 1'b0);
    wbuf[0] = $urandom;
    frame(1, 4'hF, 1'b1, 1'b1, 1'b0);
    prev_uf = 1'b1;
    for (int f = 0; f < 30; f++) begin
      ins = ($urandom_range(0, 3) == 0);
      if (ins) repeat ($urandom_range(1, 20)) @(negedge clk);
      uf = ($urandom_range(0, 5) == 0);
      nw = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
      frame(nw, 4'($urandom), !prev_uf && !ins, uf, 1'b0);
      prev_uf = uf;
    end
    wait_quiet("drain_random");
    mon_en = 1'b0;
    wbuf[0] = $urandom;
    send(wbuf[0], 4'hF, 1'b0);
    repeat (9) @(negedge clk);
    chk("pre_reset_in_data", {31'h0, tx_en}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {21'h0, s_ready, tx_en, busy, txd}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", {31'h0, s_ready}, 32'd1);
    q.delete();
    have_prev = 1'b0;
    idle = 0;
    mon_en = 1'b1;
    wbuf[0] = $urandom;
    frame(1, 4'h0, 1'b0, 1'b0, 1'b1);
    wait_quiet("drain_after_reset");
    begin
      int n;
      s2_data = 8'h5A; s2_keep = 1'b1; s2_last = 1'b1; s2_valid = 1'b1;
      n = 0;
      while (!s2_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      s2_valid = 1'b0;
      chk("nopre_first_byte", {23'h0, tx2_en, txd2}, {23'h0, 1'b1, 8'h5A});
      @(negedge clk);
      chk("nopre_after_byte", {29'h0, tx2_en, s2_ready, tx2_er | uflow2}, 32'h0);
      n = 0;
      while (!s2_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("nopre_ifg_len", n, IFG - 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
